// File: rtl/axi_pkg.sv
// AXI-lite shared types: protection and response encodings.
package axi_pkg;

    typedef logic [2:0] prot_t;
    typedef logic [1:0] resp_t;

    localparam prot_t PROT_NONE   = 3'b000;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sauria_cfg_pkg.sv
// SAURIA configuration-port defaults and the AXI-lite master FSM state encoding.
package sauria_cfg_pkg;

    localparam int CFG_AXI_ADDR_WIDTH_DEF = 32;
    localparam int CFG_AXI_DATA_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } cfg_state_e;

endpackage

// File: rtl/sauria_cfg_axil_master.sv
// Single-outstanding AXI-lite master turning a simple command/response
// interface into AXI-lite write or read transactions.
// Optional feature: define SAURIA_CFG_AXIL_TIMEOUT_EN to abort a transaction
// with SLVERR and o_rsp_timeout=1 after TIMEOUT_CYCLES busy cycles.
module sauria_cfg_axil_master
    import axi_pkg::*;
    import sauria_cfg_pkg::*;
#(
    parameter int CFG_AXI_ADDR_WIDTH = CFG_AXI_ADDR_WIDTH_DEF,
    parameter int CFG_AXI_DATA_WIDTH = CFG_AXI_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES     = 1024,
    localparam int CFG_AXI_BYTE_NUM  = CFG_AXI_DATA_WIDTH / 8
) (
    input  logic                          i_system_clk,
    input  logic                          i_system_rst,
    // command side
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_write,
    input  logic [CFG_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [CFG_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [CFG_AXI_BYTE_NUM-1:0]   i_cmd_wstrb,
    // response side
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [CFG_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output resp_t                         o_rsp_resp,
    output logic                          o_rsp_timeout,
    // AXI-lite master
    output logic [CFG_AXI_ADDR_WIDTH-1:0] o_cfg_axi_awaddr,
    output prot_t                         o_cfg_axi_awprot,
    output logic                          o_cfg_axi_awvalid,
    input  logic                          i_cfg_axi_awready,
    output logic [CFG_AXI_DATA_WIDTH-1:0] o_cfg_axi_wdata,
    output logic [CFG_AXI_BYTE_NUM-1:0]   o_cfg_axi_wstrb,
    output logic                          o_cfg_axi_wvalid,
    input  logic                          i_cfg_axi_wready,
    input  resp_t                         i_cfg_axi_bresp,
    input  logic                          i_cfg_axi_bvalid,
    output logic                          o_cfg_axi_bready,
    output logic [CFG_AXI_ADDR_WIDTH-1:0] o_cfg_axi_araddr,
    output prot_t                         o_cfg_axi_arprot,
    output logic                          o_cfg_axi_arvalid,
    input  logic                          i_cfg_axi_arready,
    input  logic [CFG_AXI_DATA_WIDTH-1:0] i_cfg_axi_rdata,
    input  resp_t                         i_cfg_axi_rresp,
    input  logic                          i_cfg_axi_rvalid,
    output logic                          o_cfg_axi_rready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    cfg_state_e                    state_q, state_d;
    logic [CFG_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [CFG_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [CFG_AXI_BYTE_NUM-1:0]   wstrb_q;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          arvalid_q, arvalid_d;
    logic [CFG_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_t                         resp_q, resp_d;
    logic                          cmd_fire;
    logic                          aw_done, w_done;
    logic                          wr_done, rd_done;
    logic                          tmo_fire;

    assign cmd_fire = i_cmd_valid && o_cmd_ready;
    // A channel is finished once its valid has dropped or handshakes this cycle.
    assign aw_done  = !awvalid_q || i_cfg_axi_awready;
    assign w_done   = !wvalid_q  || i_cfg_axi_wready;
    assign wr_done  = (state_q == ST_WR_RESP) && i_cfg_axi_bvalid;
    assign rd_done  = (state_q == ST_RD_DATA) && i_cfg_axi_rvalid;

`ifdef SAURIA_CFG_AXIL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic             busy;

    assign busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    // A genuine slave response in the last allowed cycle wins over the timeout.
    assign tmo_fire = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) &&
                      !wr_done && !rd_done;
    assign o_rsp_timeout = tmo_flag_q;

    // Busy-cycle counter restarts with every accepted command.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        if (cmd_fire) begin
            tmo_cnt_d = '0;
        end else if (busy) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (tmo_fire) begin
            tmo_flag_d = 1'b1;
        end else if (wr_done || rd_done) begin
            tmo_flag_d = 1'b0;
        end
    end

    // Timeout counter and sticky response flag.
    always_ff @(posedge i_system_clk or posedge i_system_rst) begin
        if (i_system_rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end
`else
    assign tmo_fire      = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_system_clk or posedge i_system_rst) begin
        if (i_system_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cmd_fire) state_d = i_cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if (aw_done && w_done) state_d = ST_WR_RESP;
            ST_WR_RESP: if (i_cfg_axi_bvalid) state_d = ST_RSP;
            ST_RD_REQ:  if (i_cfg_axi_arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (i_cfg_axi_rvalid) state_d = ST_RSP;
            ST_RSP:     if (i_rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (tmo_fire) begin
            state_d = ST_RSP;
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        o_cmd_ready      = 1'b0;
        o_cfg_axi_bready = 1'b0;
        o_cfg_axi_rready = 1'b0;
        o_rsp_valid      = 1'b0;
        unique case (state_q)
            ST_IDLE:    o_cmd_ready      = !i_system_rst;
            ST_WR_RESP: o_cfg_axi_bready = 1'b1;
            ST_RD_DATA: o_cfg_axi_rready = 1'b1;
            ST_RSP:     o_rsp_valid      = 1'b1;
            default:    ;
        endcase
    end

    // Next values for the registered AXI valids and the response payload.
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        if (cmd_fire) begin
            awvalid_d = i_cmd_write;
            wvalid_d  = i_cmd_write;
            arvalid_d = !i_cmd_write;
        end
        if (awvalid_q && i_cfg_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_cfg_axi_wready)   wvalid_d  = 1'b0;
        if (arvalid_q && i_cfg_axi_arready) arvalid_d = 1'b0;
        if (wr_done) begin
            rdata_d = '0;
            resp_d  = i_cfg_axi_bresp;
        end
        if (rd_done) begin
            rdata_d = i_cfg_axi_rdata;
            resp_d  = i_cfg_axi_rresp;
        end
        if (tmo_fire) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            rdata_d   = '0;
            resp_d    = RESP_SLVERR;
        end
    end

    // Command latch, AXI valids and response payload registers.
    always_ff @(posedge i_system_clk or posedge i_system_rst) begin
        if (i_system_rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            if (cmd_fire) begin
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
                wstrb_q <= i_cmd_wstrb;
            end
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign o_cfg_axi_awaddr  = addr_q;
    assign o_cfg_axi_araddr  = addr_q;
    assign o_cfg_axi_awprot  = PROT_NONE;
    assign o_cfg_axi_arprot  = PROT_NONE;
    assign o_cfg_axi_awvalid = awvalid_q;
    assign o_cfg_axi_wvalid  = wvalid_q;
    assign o_cfg_axi_arvalid = arvalid_q;
    assign o_cfg_axi_wdata   = wdata_q;
    assign o_cfg_axi_wstrb   = wstrb_q;
    assign o_rsp_rdata       = rdata_q;
    assign o_rsp_resp        = resp_q;

endmodule

// File: tb/tb_sauria_cfg_axil_master.sv
// Self-checking bench for sauria_cfg_axil_master: a vector table, hand-written
// reset / stray-response sequences and randomized transactions against a
// latency/response reference model.
module tb_sauria_cfg_axil_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sauria_cfg_axil_master #(
        .CFG_AXI_ADDR_WIDTH(32),
        .CFG_AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_system_clk(clk),           .i_system_rst(rst),
        .i_cmd_valid(cmd_valid),      .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write),      .i_cmd_addr(cmd_addr),
        .i_cmd_wdata(cmd_wdata),      .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid),      .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata),      .o_rsp_resp(rsp_resp),
        .o_rsp_timeout(rsp_timeout),
        .o_cfg_axi_awaddr(awaddr),    .o_cfg_axi_awprot(awprot),
        .o_cfg_axi_awvalid(awvalid),  .i_cfg_axi_awready(awready),
        .o_cfg_axi_wdata(wdata),      .o_cfg_axi_wstrb(wstrb),
        .o_cfg_axi_wvalid(wvalid),    .i_cfg_axi_wready(wready),
        .i_cfg_axi_bresp(bresp),      .i_cfg_axi_bvalid(bvalid),
        .o_cfg_axi_bready(bready),
        .o_cfg_axi_araddr(araddr),    .o_cfg_axi_arprot(arprot),
        .o_cfg_axi_arvalid(arvalid),  .i_cfg_axi_arready(arready),
        .i_cfg_axi_rdata(rdata),      .i_cfg_axi_rresp(rresp),
        .i_cfg_axi_rvalid(rvalid),    .o_cfg_axi_rready(rready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        int          daw, dw, db, dar, dr;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int          hold;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: cycles from the accept cycle to the first o_rsp_valid
    // cycle, derived from AXI handshake rules (one request cycle, one response
    // cycle, one cycle to present the response) plus slave wait states.
    function automatic int ref_latency(input logic wr, input int daw, input int dw,
                                       input int db, input int dar, input int dr);
        int m;
        m = (daw > dw) ? daw : dw;
        return wr ? (3 + m + db) : (3 + dar + dr);
    endfunction

    // Issue one command, play the AXI slave with the given wait states and
    // check protocol, latency and the returned response.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input int daw, input int dw, input int db, input int dar, input int dr,
                           input logic [31:0] s_rdata, input logic [1:0] s_resp, input int hold,
                           input logic [31:0] e_rdata, input logic [1:0] e_resp, input int e_lat,
                           input logic e_tmo);
        int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
        int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        int viol = 0, hviol = 0, lat = -1, k = 1;
        logic both_done = 1'b0, ar_done = 1'b0;

        @(negedge clk);
        chk({tag, ".cmd_ready_idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        while (k < 200) begin
            if (cmd_ready) viol++;
            if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
            if (awvalid && (aw_n > 0 || !wr || awaddr !== addr)) viol++;
            if (wvalid && (w_n > 0 || !wr || wdata !== wd || wstrb !== strb)) viol++;
            if (arvalid && (ar_n > 0 || wr || araddr !== addr)) viol++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            awready = awvalid && (aw_wait >= daw);
            wready  = wvalid && (w_wait >= dw);
            arready = arvalid && (ar_wait >= dar);
            bvalid  = both_done && (b_wait >= db);
            bresp   = bvalid ? s_resp : 2'b00;
            rvalid  = ar_done && (r_wait >= dr);
            rdata   = rvalid ? s_rdata : 32'h0;
            rresp   = rvalid ? s_resp : 2'b00;
            if (awvalid) begin if (awready) aw_n++; else aw_wait++; end
            if (wvalid) begin if (wready) w_n++; else w_wait++; end
            if (arvalid) begin if (arready) ar_n++; else ar_wait++; end
            if (bvalid && bready) begin b_n++; both_done = 1'b0; end
            else if (both_done) b_wait++;
            if (rvalid && rready) begin r_n++; ar_done = 1'b0; end
            else if (ar_done) r_wait++;
            if (arvalid && arready) ar_done = 1'b1;
            if (aw_n > 0 && w_n > 0 && b_n == 0) both_done = 1'b1;
            @(negedge clk);
            k++;
        end
        if (lat < 0) begin
            n_chk++; n_err++;
            $display("FAIL %s.rsp_wait: no o_rsp_valid within 200 cycles, expected at cycle %0d", tag, e_lat);
        end
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".rdata"}, rsp_rdata, e_rdata);
        chk({tag, ".resp"}, rsp_resp, e_resp);
        chk({tag, ".timeout"}, rsp_timeout, e_tmo);
        chk({tag, ".axi_quiet"}, {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk({tag, ".aw_hs"}, aw_n, (wr ? 1 : 0));
        chk({tag, ".w_hs"}, w_n, (wr ? 1 : 0));
        chk({tag, ".ar_hs"}, ar_n, (wr ? 0 : 1));
        chk({tag, ".b_hs"}, b_n, ((wr && !e_tmo) ? 1 : 0));
        chk({tag, ".r_hs"}, r_n, ((!wr && !e_tmo) ? 1 : 0));
        chk({tag, ".protocol_viol"}, viol, 0);
        // Hold the response; stray slave responses must be ignored meanwhile.
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (!rsp_valid || rsp_rdata !== e_rdata || rsp_resp !== e_resp ||
                rsp_timeout !== e_tmo || cmd_ready || bready || rready) hviol++;
            rsp_ready = (h == hold);
            bvalid = 1'b1; rvalid = 1'b1; rdata = $urandom; bresp = 2'($urandom); rresp = 2'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rdata = '0; bresp = '0; rresp = '0;
        chk({tag, ".rsp_hold_viol"}, hviol, 0);
        chk({tag, ".back_to_idle"}, {cmd_ready, rsp_valid}, 2'b10);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t        vecs[6];
        logic        r_wr;
        logic [31:0] r_addr, r_wd, r_rd;
        logic [3:0]  r_strb;
        logic [1:0]  r_resp;
        int          r_daw, r_dw, r_db, r_dar, r_dr, r_hold, cnt;

        //        wr    addr          wdata         strb  daw dw db dar dr  s_rdata       resp  hold  e_rdata       e_resp e_lat
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 32'h0,         2'b00, 3};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 32'h1234_5678, 2'b00, 3};
        vecs[2] = '{1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 4'hF, 0, 3, 0, 0, 0, 32'h0,         2'b00, 1, 32'h0,         2'b00, 6};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b10, 5, 32'hCAFE_F00D, 2'b10, 3};
        vecs[4] = '{1'b1, 32'h0000_0104, 32'h0102_0304, 4'h3, 2, 1, 2, 0, 0, 32'h0,         2'b10, 0, 32'h0,         2'b10, 7};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 0, 0, 2, 1, 32'h8000_0001, 2'b01, 2, 32'h8000_0001, 2'b01, 6};

        // Reset state: everything low, including o_cmd_ready.
        @(negedge clk);
        chk("rst.ctrl_outs", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready, rsp_timeout}, 8'h00);
        chk("rst.rsp_data", {rsp_rdata, rsp_resp}, 34'h0);
        chk("rst.axi_addr_data", {awaddr, araddr}, 64'h0);
        chk("rst.axi_wdata", {wdata, wstrb, awprot, arprot}, 42'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.cmd_ready_after", cmd_ready, 1'b1);

        // Stray B/R responses while idle must be ignored.
        cnt = 0;
        bvalid = 1'b1; rvalid = 1'b1; bresp = 2'b11; rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || bready || rready || !cmd_ready) cnt++;
        end
        bvalid = 1'b0; rvalid = 1'b0; bresp = '0; rdata = '0;
        chk("idle.stray_resp", cnt, 0);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].strb,
                    vecs[i].daw, vecs[i].dw, vecs[i].db, vecs[i].dar, vecs[i].dr,
                    vecs[i].s_rdata, vecs[i].s_resp, vecs[i].hold,
                    vecs[i].e_rdata, vecs[i].e_resp, vecs[i].e_lat, 1'b0);
        end

        // Reset asserted while waiting in RD_DATA: abandon with no response.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0044;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rstmid.arvalid", arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rstmid.rready", rready, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.async_ctrl", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready, rsp_timeout}, 8'h00);
        chk("rstmid.async_data", {rsp_rdata, rsp_resp, araddr}, 66'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        rvalid = 1'b1; rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) cnt++;
        end
        rvalid = 1'b0; rdata = '0;
        chk("rstmid.no_response", cnt, 0);
        run_txn("post_rst", 1'b0, 32'h0000_0048, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'h0BAD_C0DE, 2'b00, 0, 32'h0BAD_C0DE, 2'b00, 3, 1'b0);

`ifdef SAURIA_CFG_AXIL_TIMEOUT_EN
        // Slave never answers the write: timeout after TMO busy cycles.
        run_txn("timeout", 1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF, 0, 0, 100000, 0, 0,
                32'h0, 2'b00, 2, 32'h0, 2'b10, TMO + 1, 1'b1);
`endif

        // Randomized transactions against the reference model.
        for (int i = 0; i < 24; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = $urandom & 32'hFFFF_FFFC;
            r_wd   = $urandom;
            r_strb = 4'($urandom);
            r_rd   = $urandom;
            r_resp = 2'($urandom);
            r_daw  = $urandom_range(0, 3);
            r_dw   = $urandom_range(0, 3);
            r_db   = $urandom_range(0, 3);
            r_dar  = $urandom_range(0, 3);
            r_dr   = $urandom_range(0, 3);
            r_hold = $urandom_range(0, 2);
            run_txn($sformatf("rnd%0d", i), r_wr, r_addr, r_wd, r_strb,
                    r_daw, r_dw, r_db, r_dar, r_dr, r_rd, r_resp, r_hold,
                    (r_wr ? 32'h0 : r_rd), r_resp,
                    ref_latency(r_wr, r_daw, r_dw, r_db, r_dar, r_dr), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
